// File: rtl/generic_sram_arb_pkg.sv
// Shared types for the two-requester byte-enable SRAM arbiter: FSM states,
// requester id and the read-return pipeline entry.
package generic_sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN
   } arb_state_t;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req and the
// priority pointer, which flips to the other requester after every grant.
module rr_arb2
   import generic_sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_id_t ptr;

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (&req) begin
            gnt = (ptr == 1'b0) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   // Under contention this yields strict alternation; a lone requester
   // still hands priority to the other side each time it is served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (|gnt) begin
         ptr <= ~gnt[1];
      end
   end

endmodule

// File: rtl/generic_sram_byte_en_arb.sv
// Arbiter/sequencer in front of a single-port byte-enable SRAM: optional
// zero-fill after reset, round-robin command arbitration, read-return routing.
module generic_sram_byte_en_arb
   import generic_sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = 128,
   parameter int ADDRESS_WIDTH = 7,
   parameter int READ_LATENCY  = 2,
   parameter int INIT_ZERO     = 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_p0_req,
   output logic                      o_p0_gnt,
   input  logic                      i_p0_we,
   input  logic [ADDRESS_WIDTH-1:0]  i_p0_addr,
   input  logic [DATA_WIDTH/8-1:0]   i_p0_be,
   input  logic [DATA_WIDTH-1:0]     i_p0_wdata,
   output logic                      o_p0_rvalid,
   output logic [DATA_WIDTH-1:0]     o_p0_rdata,
   input  logic                      i_p1_req,
   output logic                      o_p1_gnt,
   input  logic                      i_p1_we,
   input  logic [ADDRESS_WIDTH-1:0]  i_p1_addr,
   input  logic [DATA_WIDTH/8-1:0]   i_p1_be,
   input  logic [DATA_WIDTH-1:0]     i_p1_wdata,
   output logic                      o_p1_rvalid,
   output logic [DATA_WIDTH-1:0]     o_p1_rdata,
   output logic [ADDRESS_WIDTH-1:0]  o_sram_address,
   output logic                      o_sram_write_enable,
   output logic [DATA_WIDTH/8-1:0]   o_sram_byte_enable,
   output logic [DATA_WIDTH-1:0]     o_sram_write_data,
   input  logic [DATA_WIDTH-1:0]     i_sram_read_data,
   output logic                      o_init_done
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = {1'b0, {ADDRESS_WIDTH{1'b1}}};

   arb_state_t                 state;
   logic [ADDRESS_WIDTH:0]     init_count;
   logic                       init_done_q;

   logic [1:0]                 gnt;
   logic                       gnt_any;
   req_id_t                    gnt_id;

   logic                       mux_we;
   logic [ADDRESS_WIDTH-1:0]   mux_addr;
   logic [BE_WIDTH-1:0]        mux_be;
   logic [DATA_WIDTH-1:0]      mux_wdata;

   logic [ADDRESS_WIDTH-1:0]   held_addr;
   logic [BE_WIDTH-1:0]        held_be;
   logic [DATA_WIDTH-1:0]      held_wdata;

   rd_entry_t                  issue_entry;
   rd_entry_t                  pipe [READ_LATENCY];

   // The zero-fill writes the last address and then hands over to RUN.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         init_count  <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (INIT_ZERO != 0) begin
                  state <= INIT;
               end else begin
                  state       <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            INIT: begin
               init_count <= init_count + 1'b1;
               if (init_count == LAST_ADDR) begin
                  state       <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            RUN: begin
               init_done_q <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   rr_arb2 u_arb (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .enable (state == RUN),
      .req    ({i_p1_req, i_p0_req}),
      .gnt    (gnt)
   );

   assign gnt_any = |gnt;
   assign gnt_id  = gnt[1];

   always_comb begin
      mux_we    = gnt_id ? i_p1_we    : i_p0_we;
      mux_addr  = gnt_id ? i_p1_addr  : i_p0_addr;
      mux_wdata = gnt_id ? i_p1_wdata : i_p0_wdata;
      mux_be    = '1;
      if (mux_we) begin
         mux_be = gnt_id ? i_p1_be : i_p0_be;
      end
   end

   // Idle cycles replay the last granted command fields so the SRAM pins stay quiet.
   always_comb begin
      o_sram_address      = held_addr;
      o_sram_write_enable = 1'b0;
      o_sram_byte_enable  = held_be;
      o_sram_write_data   = held_wdata;
      if (state == INIT) begin
         o_sram_address      = init_count[ADDRESS_WIDTH-1:0];
         o_sram_write_enable = 1'b1;
         o_sram_byte_enable  = '1;
         o_sram_write_data   = '0;
      end else if (gnt_any) begin
         o_sram_address      = mux_addr;
         o_sram_write_enable = mux_we;
         o_sram_byte_enable  = mux_be;
         o_sram_write_data   = mux_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         held_addr  <= '0;
         held_be    <= '0;
         held_wdata <= '0;
      end else if (gnt_any) begin
         held_addr  <= mux_addr;
         held_be    <= mux_be;
         held_wdata <= mux_wdata;
      end
   end

   always_comb begin
      issue_entry.valid = gnt_any & ~mux_we;
      issue_entry.id    = gnt_id;
   end

   // The last stage lines up with the SRAM's registered read data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= issue_entry;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign o_p0_gnt    = gnt[0];
   assign o_p1_gnt    = gnt[1];
   assign o_p0_rvalid = pipe[READ_LATENCY-1].valid & (pipe[READ_LATENCY-1].id == 1'b0);
   assign o_p1_rvalid = pipe[READ_LATENCY-1].valid & (pipe[READ_LATENCY-1].id == 1'b1);
   assign o_p0_rdata  = i_sram_read_data;
   assign o_p1_rdata  = i_sram_read_data;
   assign o_init_done = init_done_q;

endmodule

// File: tb/tb_generic_sram_byte_en_arb.sv
// Directed bench for generic_sram_byte_en_arb with a behavioural two-stage
// registered SRAM; a second instance covers the no-zero-fill configuration.
module tb_generic_sram_byte_en_arb;

   localparam int DW = 128;
   localparam int AW = 4;
   localparam int BW = DW / 8;
   localparam logic [DW-1:0] WR_DATA = {96'h11223344_55667788_99AABBCC, 32'hAABBCCDD};
   localparam logic [DW-1:0] RD5_DATA = {96'h0, 32'hAABBCCDD};

   int checks = 0;
   int errors = 0;

   logic clk;
   logic rst_n;
   logic preload;

   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [BW-1:0] p0_be, p1_be;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic [BW-1:0] sram_be;
   logic [DW-1:0] sram_wdata, sram_rdata;
   logic          init_done;

   logic [DW-1:0] mem [16];
   logic [DW-1:0] rd1, rd2;

   logic          n_rst_n;
   logic          n_p0_req, n_p0_we, n_p1_req, n_p1_we;
   logic [AW-1:0] n_p0_addr, n_p1_addr;
   logic [BW-1:0] n_p0_be, n_p1_be;
   logic [DW-1:0] n_p0_wdata, n_p1_wdata;
   logic          n_p0_gnt, n_p1_gnt, n_p0_rvalid, n_p1_rvalid;
   logic [DW-1:0] n_p0_rdata, n_p1_rdata;
   logic [AW-1:0] n_sram_addr;
   logic          n_sram_we;
   logic [BW-1:0] n_sram_be;
   logic [DW-1:0] n_sram_wdata;
   logic [DW-1:0] n_sram_rdata;
   logic          n_init_done;

   generic_sram_byte_en_arb #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(2), .INIT_ZERO(1)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_p0_req(p0_req), .o_p0_gnt(p0_gnt), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
      .i_p0_be(p0_be), .i_p0_wdata(p0_wdata), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
      .i_p1_req(p1_req), .o_p1_gnt(p1_gnt), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
      .i_p1_be(p1_be), .i_p1_wdata(p1_wdata), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
      .o_sram_address(sram_addr), .o_sram_write_enable(sram_we),
      .o_sram_byte_enable(sram_be), .o_sram_write_data(sram_wdata),
      .i_sram_read_data(sram_rdata), .o_init_done(init_done)
   );

   generic_sram_byte_en_arb #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(2), .INIT_ZERO(0)
   ) dut_noinit (
      .i_clk(clk), .i_rst_n(n_rst_n),
      .i_p0_req(n_p0_req), .o_p0_gnt(n_p0_gnt), .i_p0_we(n_p0_we), .i_p0_addr(n_p0_addr),
      .i_p0_be(n_p0_be), .i_p0_wdata(n_p0_wdata), .o_p0_rvalid(n_p0_rvalid), .o_p0_rdata(n_p0_rdata),
      .i_p1_req(n_p1_req), .o_p1_gnt(n_p1_gnt), .i_p1_we(n_p1_we), .i_p1_addr(n_p1_addr),
      .i_p1_be(n_p1_be), .i_p1_wdata(n_p1_wdata), .o_p1_rvalid(n_p1_rvalid), .o_p1_rdata(n_p1_rdata),
      .o_sram_address(n_sram_addr), .o_sram_write_enable(n_sram_we),
      .o_sram_byte_enable(n_sram_be), .o_sram_write_data(n_sram_wdata),
      .i_sram_read_data(n_sram_rdata), .o_init_done(n_init_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural SRAM: byte-masked writes, two registered read stages.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= {4{32'hDEADBEEF}};
      end else if (sram_we) begin
         for (int b = 0; b < BW; b++) begin
            if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end
      end
      rd1 <= mem[sram_addr];
      rd2 <= rd1;
   end
   assign sram_rdata = rd2;

   task automatic test_reset();
      rst_n = 1'b0; preload = 1'b1;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_be = '0; p0_wdata = '0;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_be = '0; p1_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, init_done} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                  {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, init_done});
      end
      checks++;
      if ({sram_addr, sram_we, sram_be, sram_wdata} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_sram: addr %0h we %b be %0h wdata %0h expected all 0",
                  sram_addr, sram_we, sram_be, sram_wdata);
      end
      p1_req = 1'b0;
   endtask

   task automatic test_init();
      @(negedge clk);
      rst_n = 1'b1; preload = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         #1;
         if (k <= 16) begin
            checks++;
            if (sram_addr !== AW'(k-1) || sram_we !== 1'b1 || sram_be !== '1 || sram_wdata !== '0) begin
               errors++;
               $display("[TB] FAIL init_write[%0d]: addr %0h we %b be %0h wdata %0h expected addr %0h we 1 be ffff wdata 0",
                        k, sram_addr, sram_we, sram_be, sram_wdata, k-1);
            end
            checks++;
            if (p0_gnt !== 1'b0 || init_done !== 1'b0) begin
               errors++;
               $display("[TB] FAIL init_hold[%0d]: gnt %b done %b expected 0 0", k, p0_gnt, init_done);
            end
         end else begin
            checks++;
            if (init_done !== 1'b1 || p0_gnt !== 1'b1) begin
               errors++;
               $display("[TB] FAIL init_done: done %b gnt %b expected 1 1", init_done, p0_gnt);
            end
         end
      end
      p0_req = 1'b0;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 4'd5; p0_be = 16'h000F; p0_wdata = WR_DATA;
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 4'd5 || sram_be !== 16'h000F || sram_wdata !== WR_DATA) begin
         errors++;
         $display("[TB] FAIL wr_drive: gnt %b we %b addr %0h be %0h expected 1 1 5 000f", p0_gnt, sram_we, sram_addr, sram_be);
      end
      @(negedge clk);
      p0_we = 1'b0; p0_be = 16'hF0F0;
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 4'd5 || sram_be !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL rd_drive: gnt %b we %b addr %0h be %0h expected 1 0 5 ffff", p0_gnt, sram_we, sram_addr, sram_be);
      end
      @(negedge clk);
      p0_req = 1'b0;
      #1;
      checks++;
      if (p0_rvalid !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 4'd5) begin
         errors++;
         $display("[TB] FAIL rd_early: rvalid %b we %b addr %0h expected 0 0 5", p0_rvalid, sram_we, sram_addr);
      end
      @(negedge clk);
      #1;
      checks++;
      if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0 || p0_rdata !== RD5_DATA) begin
         errors++;
         $display("[TB] FAIL rd_return: rvalid %b/%b rdata %0h expected 1/0 %0h", p0_rvalid, p1_rvalid, p0_rdata, RD5_DATA);
      end
      @(negedge clk);
      #1;
      checks++;
      if (p0_rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_pulse: rvalid %b expected 0", p0_rvalid);
      end
   endtask

   task automatic test_p1_only();
      for (int j = 0; j <= 6; j++) begin
         @(negedge clk);
         p1_req = (j < 4); p1_we = 1'b0; p1_addr = (j % 2 == 0) ? 4'd5 : 4'd6;
         #1;
         checks++;
         if ({p1_gnt, p0_gnt} !== ((j < 4) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("[TB] FAIL p1_only_gnt[%0d]: got %b%b expected %s", j, p1_gnt, p0_gnt, (j < 4) ? "10" : "00");
         end
         checks++;
         if (p1_rvalid !== (j >= 2 && j <= 5) || p0_rvalid !== 1'b0 ||
             (p1_rvalid === 1'b1 && p1_rdata !== ((j % 2 == 0) ? RD5_DATA : '0))) begin
            errors++;
            $display("[TB] FAIL p1_only_rvalid[%0d]: rvalid %b/%b rdata %0h", j, p0_rvalid, p1_rvalid, p1_rdata);
         end
      end
   endtask

   task automatic test_back_to_back();
      int seen;
      seen = 0;
      for (int j = 0; j <= 8; j++) begin
         @(negedge clk);
         p0_req = (j < 6); p0_we = 1'b0; p0_addr = 4'd5;
         p1_req = (j < 6); p1_we = 1'b0; p1_addr = 4'd6;
         #1;
         checks++;
         if ({p1_gnt, p0_gnt} !== ((j >= 6) ? 2'b00 : ((j % 2 == 0) ? 2'b01 : 2'b10))) begin
            errors++;
            $display("[TB] FAIL b2b_gnt[%0d]: got %b%b", j, p1_gnt, p0_gnt);
         end
         checks++;
         if (p0_rvalid !== (j >= 2 && j <= 7 && j % 2 == 0) || p1_rvalid !== (j >= 2 && j <= 7 && j % 2 == 1) ||
             (p0_rvalid === 1'b1 && p0_rdata !== RD5_DATA) || (p1_rvalid === 1'b1 && p1_rdata !== '0)) begin
            errors++;
            $display("[TB] FAIL b2b_rvalid[%0d]: rvalid %b/%b rdata %0h", j, p0_rvalid, p1_rvalid, p0_rdata);
         end
         if (p0_rvalid === 1'b1) seen++;
         if (p1_rvalid === 1'b1) seen++;
      end
      checks++;
      if (seen != 6) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d returns expected 6", seen);
      end
   endtask

   task automatic test_reset_inflight();
      for (int j = 0; j <= 4; j++) begin
         @(negedge clk);
         p0_req = (j < 2); p0_we = 1'b0; p0_addr = 4'd5; p1_req = 1'b0;
         if (j == 2 || j == 3) rst_n = 1'b0;
         if (j == 4) rst_n = 1'b1;
         #1;
         if (j >= 2) begin
            checks++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || init_done !== 1'b0) begin
               errors++;
               $display("[TB] FAIL rst_flush[%0d]: rvalid %b/%b done %b expected 0/0 0", j, p0_rvalid, p1_rvalid, init_done);
            end
         end
      end
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (p0_rvalid !== 1'b0 || (k <= 16 && (sram_addr !== AW'(k-1) || sram_we !== 1'b1)) || init_done !== (k == 17)) begin
            errors++;
            $display("[TB] FAIL rst_reinit[%0d]: rvalid %b addr %0h we %b done %b", k, p0_rvalid, sram_addr, sram_we, init_done);
         end
      end
   endtask

   task automatic test_no_init();
      @(negedge clk);
      n_rst_n = 1'b1;
      n_p0_req = 1'b1; n_p0_we = 1'b1; n_p0_addr = 4'd3; n_p0_be = 16'h00FF; n_p0_wdata = WR_DATA;
      #1;
      checks++;
      if (n_init_done !== 1'b0 || n_p0_gnt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL noinit_idle: done %b gnt %b expected 0 0", n_init_done, n_p0_gnt);
      end
      @(negedge clk);
      #1;
      checks++;
      if (n_init_done !== 1'b1 || n_p0_gnt !== 1'b1 || n_sram_we !== 1'b1 || n_sram_addr !== 4'd3 || n_sram_be !== 16'h00FF) begin
         errors++;
         $display("[TB] FAIL noinit_run: done %b gnt %b we %b addr %0h be %0h expected 1 1 1 3 00ff",
                  n_init_done, n_p0_gnt, n_sram_we, n_sram_addr, n_sram_be);
      end
      n_p0_req = 1'b0;
   endtask

   initial begin
      n_rst_n = 1'b0;
      n_p0_req = 1'b0; n_p0_we = 1'b0; n_p0_addr = '0; n_p0_be = '0; n_p0_wdata = '0;
      n_p1_req = 1'b0; n_p1_we = 1'b0; n_p1_addr = '0; n_p1_be = '0; n_p1_wdata = '0;
      n_sram_rdata = '0;
      test_reset();
      test_init();
      test_write_read();
      test_p1_only();
      test_back_to_back();
      test_reset_inflight();
      test_no_init();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
